// File: rtl/video_pattern_pkg.sv
// video_pattern_pkg
//   Shared types and constants for the test-pattern stream generator.
//   - rgb_t       : packed {r,g,b} pixel, 8 bits per component
//   - pattern_e   : per-frame pattern selection code
//   - BAR_COLOURS : the eight colour-bar colours, left to right
//   - state_e     : stream FSM states
package video_pattern_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    PAT_GRID  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam rgb_t BAR_COLOURS [8] = '{
    rgb_t'(24'hFFFFFF),  // white
    rgb_t'(24'hFFFF00),  // yellow
    rgb_t'(24'h00FFFF),  // cyan
    rgb_t'(24'h00FF00),  // green
    rgb_t'(24'hFF00FF),  // magenta
    rgb_t'(24'hFF0000),  // red
    rgb_t'(24'h0000FF),  // blue
    rgb_t'(24'h000000)   // black
  };

endpackage

// File: rtl/pattern_pixel.sv
// pattern_pixel
//   Purely combinational colour function for one pixel.
//   Ports:
//     gx       in  XW  horizontal pattern coordinate (may be scrolled)
//     gy       in  YW  vertical pattern coordinate
//     bar_idx  in  3   colour-bar index, already saturated at 7
//     pattern  in      pattern select for the frame
//     solid    in      colour used by the solid pattern
//     pixel    out     resulting {r,g,b}
module pattern_pixel
  import video_pattern_pkg::*;
#(
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int GRID_LOG2 = 4
) (
  input  logic [XW-1:0] gx,
  input  logic [YW-1:0] gy,
  input  logic [2:0]    bar_idx,
  input  pattern_e      pattern,
  input  rgb_t          solid,
  output rgb_t          pixel
);

  // Masks select the low GRID_LOG2 bits; if the grid pitch exceeds a
  // coordinate's range the mask simply covers the whole coordinate.
  localparam logic [XW-1:0] GX_MASK = XW'((1 << GRID_LOG2) - 1);
  localparam logic [YW-1:0] GY_MASK = YW'((1 << GRID_LOG2) - 1);

  logic grid_line;
  assign grid_line = ((gx & GX_MASK) == '0) || ((gy & GY_MASK) == '0);

  always_comb begin
    pixel = '0;
    case (pattern)
      PAT_GRID:  pixel = grid_line ? rgb_t'(24'hFFFFFF) : rgb_t'(24'h000000);
      PAT_BARS:  pixel = BAR_COLOURS[bar_idx];
      PAT_GRAD: begin
        pixel.r = 8'(gx);
        pixel.g = 8'(gy);
        pixel.b = 8'(gx) + 8'(gy);
      end
      PAT_SOLID: pixel = solid;
      default:   pixel = '0;
    endcase
  end

endmodule

// File: rtl/pattern_stream_gen.sv
// pattern_stream_gen
//   Emits frames of HDISP x VDISP RGB pixels in raster order on a
//   valid/ready stream. Pattern and solid colour are latched per frame.
//   Optional macro PATTERN_STREAM_ANIM_EN: grid and gradient scroll
//   horizontally by one pixel per completed frame.
//   Ports:
//     pixel_clk    in   clock, rising edge
//     pixel_rst    in   synchronous active-high reset
//     enable       in   frame request, sampled at frame boundaries only
//     pattern_sel  in   0 grid, 1 bars, 2 gradient, 3 solid
//     solid_rgb    in   colour for the solid pattern
//     out_valid    out  pixel available
//     out_ready    in   downstream accepts pixel
//     out_data     out  pixel {R,G,B}
//     out_sof      out  marks pixel (0,0)
//     out_eol      out  marks the last pixel of a line
//     frame_done   out  one-cycle pulse after the last pixel is accepted
//     frame_cnt    out  completed frames, mod 256
module pattern_stream_gen
  import video_pattern_pkg::*;
#(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int GRID_LOG2 = 4
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int XW     = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW     = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BARW   = (HDISP / 8 > 0) ? HDISP / 8 : 1;
  localparam int BCW    = (BARW > 1) ? $clog2(BARW) : 1;
  localparam logic [XW-1:0]  X_LAST  = XW'(HDISP - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(VDISP - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BARW - 1);

  state_e         state_reg, state_next;
  logic [XW-1:0]  x_reg, x_next;
  logic [YW-1:0]  y_reg, y_next;
  logic [BCW-1:0] bar_cnt_reg, bar_cnt_next;
  logic [2:0]     bar_idx_reg, bar_idx_next;
  pattern_e       pat_reg, pat_next;
  rgb_t           solid_reg, solid_next;
  logic [7:0]     fcnt_reg, fcnt_next;
  logic           done_reg, done_next;
  rgb_t           data_reg;
  logic           sof_reg, eol_reg;
  logic           load;
  logic [XW-1:0]  gx;
  rgb_t           pix;

  // x/y registers hold the coordinate of the pixel currently presented;
  // the output register is loaded from the *next* coordinate so data is
  // ready in the same cycle as out_valid.
  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    bar_cnt_next = bar_cnt_reg;
    bar_idx_next = bar_idx_reg;
    pat_next     = pat_reg;
    solid_next   = solid_reg;
    fcnt_next    = fcnt_reg;
    done_next    = 1'b0;
    load         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next   = STREAM;
          pat_next     = pattern_e'(pattern_sel);
          solid_next   = rgb_t'(solid_rgb);
          x_next       = '0;
          y_next       = '0;
          bar_cnt_next = '0;
          bar_idx_next = '0;
          load         = 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          load = 1'b1;
          if (x_reg == X_LAST) begin
            x_next       = '0;
            bar_cnt_next = '0;
            bar_idx_next = '0;
            if (y_reg == Y_LAST) begin
              y_next    = '0;
              done_next = 1'b1;
              fcnt_next = fcnt_reg + 8'd1;
              if (enable) begin
                // Back-to-back frame: new settings apply from pixel (0,0).
                pat_next   = pattern_e'(pattern_sel);
                solid_next = rgb_t'(solid_rgb);
              end else begin
                state_next = IDLE;
                load       = 1'b0;
              end
            end else begin
              y_next = y_reg + YW'(1);
            end
          end else begin
            x_next = x_reg + XW'(1);
            // Bar index advances every BARW pixels and sticks at 7, so any
            // leftover pixels at the right edge fall into the last bar.
            if (bar_cnt_reg == BC_LAST) begin
              bar_cnt_next = '0;
              if (bar_idx_reg != 3'd7) begin
                bar_idx_next = bar_idx_reg + 3'd1;
              end
            end else begin
              bar_cnt_next = bar_cnt_reg + BCW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef PATTERN_STREAM_ANIM_EN
  assign gx = x_next + XW'(fcnt_next);
`else
  assign gx = x_next;
`endif

  pattern_pixel #(
    .XW        (XW),
    .YW        (YW),
    .GRID_LOG2 (GRID_LOG2)
  ) u_pixel (
    .gx      (gx),
    .gy      (y_next),
    .bar_idx (bar_idx_next),
    .pattern (pat_next),
    .solid   (solid_next),
    .pixel   (pix)
  );

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
      pat_reg     <= PAT_GRID;
      solid_reg   <= '0;
      fcnt_reg    <= '0;
      done_reg    <= 1'b0;
      data_reg    <= '0;
      sof_reg     <= 1'b0;
      eol_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      bar_cnt_reg <= bar_cnt_next;
      bar_idx_reg <= bar_idx_next;
      pat_reg     <= pat_next;
      solid_reg   <= solid_next;
      fcnt_reg    <= fcnt_next;
      done_reg    <= done_next;
      if (load) begin
        data_reg <= pix;
        sof_reg  <= (x_next == '0) && (y_next == '0);
        eol_reg  <= (x_next == X_LAST);
      end else if (state_next == IDLE) begin
        sof_reg <= 1'b0;
        eol_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = (state_reg == STREAM);
  assign out_data   = data_reg;
  assign out_sof    = sof_reg;
  assign out_eol    = eol_reg;
  assign frame_done = done_reg;
  assign frame_cnt  = fcnt_reg;

endmodule

// File: doc/pattern_stream_gen.md
Name: pattern_stream_gen

Overview:
- Upstream pixel source for the VGA timing stage: emits one full frame of HDISP x VDISP 24-bit RGB pixels in raster order over a valid/ready stream.
- Output feeds the pixel FIFO in front of the VGA output stage.
- Patterns are selectable per frame: grid, colour bars, gradient, solid colour.
- Used for bring-up and as a fallback source when the framebuffer path is idle.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
GRID_LOG2, 4, grid pitch is 2**GRID_LOG2 pixels

Ports:
pixel_clk  in  1  pixel clock, all logic on rising edge
pixel_rst  in  1  synchronous, active-high reset
enable  in  1  request frame generation; sampled only at frame boundaries
pattern_sel  in  2  0 grid, 1 colour bars, 2 gradient, 3 solid
solid_rgb  in  24  {R,G,B} colour for pattern 3
out_valid  out  1  pixel available
out_ready  in  1  downstream accepts pixel
out_data  out  24  pixel {R[7:0],G[7:0],B[7:0]}
out_sof  out  1  qualifies pixel (0,0)
out_eol  out  1  qualifies pixel x=HDISP-1
frame_done  out  1  one-cycle pulse on acceptance of pixel (HDISP-1,VDISP-1)
frame_cnt  out  8  frames completed, mod 256

Behaviour:
- Reset is synchronous, active-high. While pixel_rst is high, or on the first edge it is sampled high:
  - state=IDLE; x=0, y=0.
  - out_valid, out_sof, out_eol, frame_done = 0.
  - out_data = 0, frame_cnt = 0.
  - This applies mid-frame too: the partial frame is abandoned, with no frame_done.
- States:
  - IDLE: out_valid=0. If enable=1, latch pattern_sel and solid_rgb into frame registers and go to STREAM. First valid pixel (0,0) appears the cycle after enable is sampled high.
  - STREAM: out_valid=1.
- Handshake: a transfer happens when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_sof and out_eol hold stable.
  - Counters advance only on a transfer. One pixel per cycle is sustained when out_ready=1.
- Counters:
  - x increments per transfer. At x=HDISP-1 it wraps to 0 and y increments.
  - At (HDISP-1, VDISP-1) both wrap to 0.
  - Widths are $clog2(HDISP) and $clog2(VDISP).
- End of frame, on transfer of the last pixel:
  - frame_done=1 on the next cycle only, and frame_cnt increments.
  - If enable=1: stay in STREAM, relatch pattern_sel and solid_rgb, present (0,0) with out_sof on the next cycle, with no bubble.
  - If enable=0: go to IDLE, out_valid=0 on the next cycle.
- Deasserting enable mid-frame has no effect until the frame completes. pattern_sel and solid_rgb changes mid-frame are ignored.
- out_data is registered and computed from the next (x,y) so that it is valid together with out_valid.
- Patterns (gx = x, gy = y):
  - Grid: white 0xFFFFFF if gx[GRID_LOG2-1:0]==0 or gy[GRID_LOG2-1:0]==0, else black.
  - Colour bars: BARW = HDISP/8 (integer). The bar index comes from a counter that increments every BARW pixels, saturates at 7 and resets at line start; no divider. Any remainder belongs to bar 7. Colours in order: white, yellow, cyan, green, magenta, red, blue, black (components 0x00 or 0xFF).
  - Gradient: R=gx[7:0], G=gy[7:0], B=(gx+gy) truncated to 8 bits.
  - Solid: latched solid_rgb.
- out_ready may be asserted with out_valid=0; it has no effect.

Optional Feature:
- Macro: PATTERN_STREAM_ANIM_EN
- Defined: gx = x + frame_cnt, truncated to x width, for the grid and gradient patterns, so those patterns scroll 1 pixel per frame. Colour bars and solid are unaffected.
- Undefined: gx = x. frame_cnt still counts.

Decomposition:
- Package video_pattern_pkg:
  - rgb_t, a packed 24-bit struct r/g/b.
  - pattern_e enum (PAT_GRID, PAT_BARS, PAT_GRAD, PAT_SOLID).
  - BAR_COLOURS constant array of 8 rgb_t.
  - state enum (IDLE, STREAM).
- One sub-module, pattern_pixel: combinational colour function of (gx, gy, bar_idx, pattern, solid). The top keeps the counters, FSM and output register.

Test Plan:
- Reset, enable=1, pattern 0, out_ready=1: out_valid rises 1 cycle after reset release; first pixel 0xFFFFFF with out_sof=1; pixel (1,1)=0x000000; out_eol every 800 transfers; frame_done after exactly 384000 transfers.
- Pattern 1, out_ready=1: pixel x=99 is 0xFFFFFF, x=100 is 0xFFFF00, x=799 is 0x000000 on every line.
- Random out_ready backpressure, pattern 2: out_data is stable while stalled; pixel (300,200)=0x2CC8F4; total transfers per frame = 384000.
- Switch pattern_sel from 0 to 3 (solid_rgb=0x123456) and drop enable mid-frame: the current frame completes as grid; the next frame is all 0x123456 only if enable was re-raised before the last transfer, otherwise out_valid=0 after frame_done.
- Assert pixel_rst at pixel (400,100): outputs are 0 on the next edge; after release the stream restarts at (0,0) with out_sof; frame_cnt=0.
- With PATTERN_STREAM_ANIM_EN defined, grid pattern: in frame 1 (frame_cnt=1) the white column is at x=15 instead of x=0; frame_cnt wraps 255 to 0.
